// File: rtl/serial_addf_seq_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_addf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit-counter width; never less than one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addf_bit.sv
// Single combinational full-adder bit; same truth table as the library addf
// cell so it can be replaced by the hard cell at synthesis.
module serial_addf_bit (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_addf_seq.sv
// Bit-serial adder controller: one full-adder cell time-shared over WIDTH bits.
// Optional subtract mode is enabled by defining SERIAL_ADDF_SEQ_SUB_EN.
module serial_addf_seq
  import serial_addf_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
`ifdef SERIAL_ADDF_SEQ_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             BUSY
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_addf_seq: WIDTH out of range");
  end

  // Supply pins are present only for netlist connectivity.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             sub_in;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDF_SEQ_SUB_EN
  assign sub_in = SUB;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction inverts B on its way into the cell, not in the shift register.
  serial_addf_bit u_bit (
    .A  (a_sh_q[0]),
    .B  (b_sh_q[0] ^ sub_q),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = CI ^ sub_in;
          sub_d   = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        // Outputs are loaded only on the final bit so they never show partials.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign BUSY      = (state_q != IDLE);
  assign S         = sum_q;
  assign CO        = co_q;

endmodule

// File: tb/tb_serial_addf_seq.sv
// Scoreboard bench for serial_addf_seq at WIDTH=8; subtract tests run when
// SERIAL_ADDF_SEQ_SUB_EN is defined.
module tb_serial_addf_seq;

  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] word_t;
  typedef struct packed {
    word_t s;
    logic  co;
  } exp_t;

  logic  CLK = 1'b0;
  logic  RN  = 1'b0;
  wire   VDD;
  wire   VSS;
  logic  IN_VALID, IN_READY, CI, OUT_VALID, OUT_READY, CO, BUSY;
  word_t A, B, S;
  logic  sub_drv;

  assign VDD = 1'b1;
  assign VSS = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  serial_addf_seq #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RN        (RN),
    .VDD       (VDD),
    .VSS       (VSS),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CI        (CI),
`ifdef SERIAL_ADDF_SEQ_SUB_EN
    .SUB       (sub_drv),
`endif
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .CO        (CO),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input word_t a, input word_t b, input logic ci, input logic sub);
    logic [WIDTH:0] r;
    word_t bb;
    exp_t e;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(ci ^ sub);
    e.s  = r[WIDTH-1:0];
    e.co = r[WIDTH];
    return e;
  endfunction

  // Waits for IN_READY, presents one operand set for one edge, records expectation.
  task automatic send(input word_t a, input word_t b, input logic ci, input logic sub);
    int n;
    n = 0;
    while (!IN_READY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!IN_READY) begin
      errors++;
      $display("FAIL send_timeout: IN_READY=%b after %0d cycles, required 1", IN_READY, n);
    end
    A = a; B = b; CI = ci; sub_drv = sub; IN_VALID = 1'b1;
    sb_q.push_back(model(a, b, ci, sub));
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  // Waits (bounded) for OUT_VALID; optionally scrambles operand inputs meanwhile.
  task automatic collect(input bit scramble, output int lat, output word_t s,
                         output logic co, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!OUT_VALID && lat < 40) begin
      if (IN_READY) rdy_seen = 1'b1;
      if (scramble) begin
        A = word_t'($urandom); B = word_t'($urandom);
        CI = 1'($urandom); sub_drv = 1'($urandom);
      end
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (!OUT_VALID) begin
      errors++;
      $display("FAIL collect_timeout: OUT_VALID=%b after %0d cycles, required 1", OUT_VALID, lat);
    end
    s = S;
    co = CO;
  endtask

  task automatic retire();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({IN_READY, OUT_VALID, BUSY, S, CO} !== {1'b1, 1'b0, 1'b0, word_t'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b S=%h CO=%b, required 1 0 0 00 0",
               IN_READY, OUT_VALID, BUSY, S, CO);
    end
    RN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int lat; word_t s; logic co; bit rdy; exp_t e;
    send(8'h5A, 8'h33, 1'b0, 1'b0);
    collect(1'b0, lat, s, co, rdy);
    e = sb_q.pop_front();
    checks++;
    if (lat !== WIDTH) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, required %0d", lat, WIDTH);
    end
    checks++;
    if ({s, co} !== {e.s, e.co}) begin
      errors++; $display("FAIL basic_result: S=%h CO=%b, required S=%h CO=%b", s, co, e.s, e.co);
    end
    checks++;
    if (rdy !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL basic_ready: ready_seen=%b busy=%b, required 0 1", rdy, BUSY);
    end
    retire();
  endtask

  task automatic test_carry_chain();
    word_t va[3] = '{8'hFF, 8'hFF, 8'h80};
    word_t vb[3] = '{8'h01, 8'hFF, 8'h80};
    logic  vc[3] = '{1'b0, 1'b1, 1'b0};
    int lat; word_t s; logic co; bit rdy; exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vc[i], 1'b0);
      collect(1'b0, lat, s, co, rdy);
      e = sb_q.pop_front();
      checks++;
      if ({s, co} !== {e.s, e.co}) begin
        errors++;
        $display("FAIL carry_chain[%0d]: S=%h CO=%b, required S=%h CO=%b", i, s, co, e.s, e.co);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat; word_t s; logic co; bit rdy; exp_t e;
    send(8'h12, 8'h34, 1'b1, 1'b0);
    collect(1'b0, lat, s, co, rdy);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin IN_VALID = 1'b1; A = 8'hFF; B = 8'hFF; CI = 1'b1; end
      if (i == 2) IN_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, IN_READY, S, CO} !== {1'b1, 1'b0, e.s, e.co}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b S=%h CO=%b, required 1 0 %h %b",
                 i, OUT_VALID, IN_READY, S, CO, e.s, e.co);
      end
    end
    retire();
    checks++;
    if ({OUT_VALID, IN_READY, BUSY, S, CO} !== {1'b0, 1'b1, 1'b0, e.s, e.co}) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b S=%h CO=%b, required 0 1 0 %h %b",
               OUT_VALID, IN_READY, BUSY, S, CO, e.s, e.co);
    end
  endtask

  task automatic test_back_to_back();
    int t[2]; int accepts; int results; exp_t e;
    accepts = 0; results = 0; t[0] = 0; t[1] = 0;
    OUT_READY = 1'b1;
    A = 8'hC3; B = 8'h5E; CI = 1'b0; sub_drv = 1'b0; IN_VALID = 1'b1;
    for (int cyc = 0; cyc < 60 && results < 2; cyc++) begin
      if (OUT_VALID) begin
        e = sb_q.pop_front();
        results++;
        checks++;
        if ({S, CO} !== {e.s, e.co}) begin
          errors++;
          $display("FAIL b2b_result[%0d]: S=%h CO=%b, required S=%h CO=%b", results, S, CO, e.s, e.co);
        end
      end
      if (IN_VALID && IN_READY && accepts < 2) begin
        t[accepts] = cyc;
        sb_q.push_back(model(A, B, CI, 1'b0));
        accepts++;
      end
      @(negedge CLK);
      if (accepts == 1) begin A = 8'h7D; B = 8'h91; CI = 1'b1; end
      if (accepts == 2) IN_VALID = 1'b0;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    checks++;
    if (accepts != 2 || results != 2 || (t[1] - t[0]) != WIDTH + 2) begin
      errors++;
      $display("FAIL b2b_interval: accepts=%0d results=%0d interval=%0d, required 2 2 %0d",
               accepts, results, t[1] - t[0], WIDTH + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; word_t s; logic co; bit rdy; exp_t e;
    send(8'h77, 8'h11, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RN = 1'b0;
    #1;
    void'(sb_q.pop_back());
    checks++;
    if ({IN_READY, OUT_VALID, BUSY, S, CO} !== {1'b1, 1'b0, 1'b0, word_t'(0), 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b S=%h CO=%b, required 1 0 0 00 0",
               IN_READY, OUT_VALID, BUSY, S, CO);
    end
    @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);
    send(8'h01, 8'h02, 1'b0, 1'b0);
    collect(1'b0, lat, s, co, rdy);
    e = sb_q.pop_front();
    checks++;
    if ({s, co} !== {e.s, e.co}) begin
      errors++; $display("FAIL midrun_next: S=%h CO=%b, required S=%h CO=%b", s, co, e.s, e.co);
    end
    retire();
  endtask

  task automatic test_isolation();
    int lat; word_t s; logic co; bit rdy; exp_t e;
    send(8'hA7, 8'h4C, 1'b1, 1'b0);
    collect(1'b1, lat, s, co, rdy);
    e = sb_q.pop_front();
    sub_drv = 1'b0;
    checks++;
    if ({s, co} !== {e.s, e.co}) begin
      errors++; $display("FAIL isolation: S=%h CO=%b, required S=%h CO=%b", s, co, e.s, e.co);
    end
    retire();
  endtask

  task automatic test_random();
    int lat; word_t s; logic co; bit rdy; exp_t e;
    for (int i = 0; i < 6; i++) begin
      send(word_t'($urandom), word_t'($urandom), 1'($urandom), 1'b0);
      collect(1'b0, lat, s, co, rdy);
      e = sb_q.pop_front();
      checks++;
      if ({s, co} !== {e.s, e.co}) begin
        errors++;
        $display("FAIL random[%0d]: S=%h CO=%b, required S=%h CO=%b", i, s, co, e.s, e.co);
      end
      retire();
    end
  endtask

`ifdef SERIAL_ADDF_SEQ_SUB_EN
  task automatic test_sub();
    word_t va[3] = '{8'h10, 8'h00, 8'h3C};
    word_t vb[3] = '{8'h01, 8'h01, 8'h3C};
    int lat; word_t s; logic co; bit rdy; exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], 1'b0, 1'b1);
      collect(1'b0, lat, s, co, rdy);
      e = sb_q.pop_front();
      checks++;
      if ({s, co} !== {e.s, e.co} || lat !== WIDTH) begin
        errors++;
        $display("FAIL sub[%0d]: S=%h CO=%b lat=%0d, required S=%h CO=%b lat=%0d",
                 i, s, co, lat, e.s, e.co, WIDTH);
      end
      retire();
    end
    sub_drv = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    A = '0; B = '0; CI = 1'b0; sub_drv = 1'b0;
    IN_VALID = 1'b0; OUT_READY = 1'b0; RN = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_isolation();
    test_random();
`ifdef SERIAL_ADDF_SEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addf_seq.md
Name: serial_addf_seq

Overview:
- Bit-serial adder controller that time-shares one full-adder bit cell across a WIDTH-bit add.
- Accepts two operands plus carry-in on a valid/ready handshake, then feeds bit pairs LSB-first through the cell, one bit per clock.
- Holds the carry in a flop between bits and returns the sum and carry-out on a second valid/ready handshake.
- Area-optimised arithmetic for slow control paths in the 5V 9-track library.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- VDD  inout  1  power
- VSS  inout  1  ground
- IN_VALID  input  1  operand request
- IN_READY  output  1  controller can accept operands
- A  input  WIDTH  operand A, sampled only at accept
- B  input  WIDTH  operand B, sampled only at accept
- CI  input  1  carry-in, sampled only at accept
- OUT_VALID  output  1  S/CO valid
- OUT_READY  input  1  consumer accepts result
- S  output  WIDTH  sum
- CO  output  1  carry-out of bit WIDTH-1
- BUSY  output  1  high in RUN or DONE

Behaviour:
- Clock/reset (already decided): one clock, CLK; reset RN is asynchronous and active-low.
- Reset (RN=0, asynchronous):
  - state=IDLE; IN_READY=1; OUT_VALID=0; BUSY=0; S=0; CO=0.
  - Carry flop=0; bit counter=0; operand shift registers=0.
- State IDLE:
  - IN_READY=1.
  - On IN_VALID&&IN_READY at a rising edge: load a_sh<=A, b_sh<=B, carry<=CI, cnt<=0; go RUN.
- State RUN (WIDTH cycles), each edge:
  - (s,c)=FA(a_sh[0],b_sh[0],carry).
  - s_sh<={s,s_sh[WIDTH-1:1]}; carry<=c.
  - a_sh and b_sh shift right by 1; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: CO<=c, go DONE.
- State DONE:
  - OUT_VALID=1; S=s_sh; CO holds.
  - On OUT_READY: go IDLE and drop OUT_VALID.
- Latency and throughput:
  - OUT_VALID rises exactly WIDTH cycles after the accept edge.
  - Minimum initiation interval is WIDTH+2 cycles (IDLE->RUN->DONE->IDLE).
  - No accept overlaps DONE.
- IN_READY=0 in RUN and DONE. IN_VALID is ignored there, and A/B/CI changes after accept have no effect.
- S and CO:
  - Stable for the whole DONE state, whatever the OUT_READY backpressure duration.
  - After returning to IDLE they keep their last value until the next completion; S updates only via s_sh.
- Counter width: $clog2(WIDTH). No wrap occurs, because the counter is reset at accept.
- Reset mid-RUN or mid-DONE: the partial result is discarded and all outputs take their reset values immediately (asynchronously). The first edge after RN release sees IDLE.
- OUT_READY asserted while OUT_VALID=0 has no effect.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDF_SEQ_SUB_EN.
- Defined:
  - Adds port SUB input 1, sampled at accept.
  - When SUB=1, b_sh bits are inverted before the cell and the carry is initialised to CI^SUB. CI=0,SUB=1 therefore yields S=A-B, with CO=1 meaning no borrow.
- Undefined: no SUB port; pure addition. Timing is identical in both builds.

Decomposition:
- Package serial_addf_seq_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - WIDTH_MIN=2, WIDTH_MAX=32 constants;
  - a cnt-width helper function.
- Sub-module serial_addf_bit: a single combinational full-adder bit with ports A, B, CI, S, CO and the same truth table as the library addf cell. It is kept separate so it can be swapped for the hard cell at synthesis.

Test Plan (WIDTH=8):
- Basic add: accept A=0x5A, B=0x33, CI=0 -> OUT_VALID exactly 8 cycles after accept; S=0x8D, CO=0; IN_READY=0 throughout.
- Carry chain:
  - A=0xFF, B=0x01, CI=0 -> S=0x00, CO=1.
  - A=0xFF, B=0xFF, CI=1 -> S=0xFF, CO=1.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> S/CO/OUT_VALID stable and a pulsed IN_VALID is ignored. Then OUT_READY=1 -> IDLE next cycle and a new accept succeeds; back-to-back interval = 10 cycles.
- Reset mid-RUN: pulse RN low after the 3rd bit edge -> IN_READY=1, BUSY=0, S=0, CO=0 immediately. Next op A=0x01, B=0x02 -> S=0x03.
- Input isolation: change A/B/CI every cycle during RUN -> result equals the values sampled at accept.
- With SERIAL_ADDF_SEQ_SUB_EN:
  - A=0x10, B=0x01, SUB=1, CI=0 -> S=0x0F, CO=1.
  - A=0x00, B=0x01, SUB=1 -> S=0xFF, CO=0.
